terminal_uart: RTL and testbench

Memory-mapped terminal/UART peripheral on the CPU data bus. Generalises the single-byte terminal port to parametrised TX/RX FIFOs, a real 8N1 serial transmitter and receiver with a programmable baud divisor, sticky error flags and a level interrupt. It also keeps the 8-bit `terminal_bus` debug output.

---
 rtl/terminal_uart_pkg.sv | 50 +++++
 rtl/terminal_fifo.sv | 66 ++++++
 rtl/terminal_uart.sv | 232 +++++++++++++++++++++++
 tb/tb_terminal_uart.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/terminal_uart_pkg.sv
// Shared constants for the terminal/UART peripheral: register map, status/control
// bit positions, serial FSM encodings and the control reset value.
package terminal_uart_pkg;

  localparam logic [2:0] ADDR_TERM    = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_RXDATA  = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_CTRL    = 3'd4;
  localparam logic [2:0] ADDR_DIVISOR = 3'd5;
  localparam logic [2:0] ADDR_CLEAR   = 3'd6;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_RX_OVF    = 5;
  localparam int ST_TX_OVF    = 6;
  localparam int ST_FRAME_ERR = 7;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_IRQ_RX_EN = 2;
  localparam int CTRL_IRQ_TX_EN = 3;

  localparam int CLR_RX_OVF    = 5;
  localparam int CLR_TX_OVF    = 6;
  localparam int CLR_FRAME_ERR = 7;
  localparam int CLR_TX_FLUSH  = 8;
  localparam int CLR_RX_FLUSH  = 9;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [3:0] CTRL_RESET = 4'h3;

  // A divisor below 2 would make the half-bit sample point collapse.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/terminal_fifo.sv
// Count-based synchronous FIFO; simultaneous push and pop always both succeed,
// flush wins over any same-cycle push or pop.
module terminal_fifo
  import terminal_uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_MAX);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_push_s = push & (~full | pop);
  assign do_pop_s  = pop & (~empty | push);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/terminal_uart.sv
// Memory-mapped terminal port plus 8N1 UART with TX/RX FIFOs, programmable
// baud divisor, sticky error flags and a registered level interrupt.
module terminal_uart
  import terminal_uart_pkg::*;
#(
  parameter int          TX_DEPTH    = 16,
  parameter int          RX_DEPTH    = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] data_write,
  output logic [31:0] data_read,
  output logic [7:0]  terminal_bus,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        irq
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  logic [7:0]  term_r;
  logic [3:0]  ctrl_r;
  logic [15:0] div_r;
  logic        rx_ovf_r, tx_ovf_r, frame_err_r, irq_r;
  logic        sel_s, wr_s, clr_s;
  logic [2:0]  reg_s;
  logic        tx_push_s, tx_pop_s, tx_flush_s, tx_full_s, tx_empty_s;
  logic        rx_push_s, rx_pop_s, rx_flush_s, rx_full_s, rx_empty_s;
  logic [7:0]  tx_dout_s, rx_dout_s;
  logic [TXCW-1:0] tx_count_s;
  logic [RXCW-1:0] rx_count_s;
  logic [1:0]  tx_state_r, rx_state_r;
  logic [15:0] tx_cnt_r, tx_div_r, rx_cnt_r, rx_div_r;
  logic [2:0]  tx_bit_r, rx_bit_r;
  logic [7:0]  tx_shift_r, rx_shift_r;
  logic        txd_r, tx_bit_end_s, rx_bit_end_s, rxd_s, rxd_prev_r, frame_err_set_s;
  logic [15:0] rx_half_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic        unused_bits_s;

  assign sel_s      = (addr[31:3] == 29'd0);
  assign reg_s      = addr[2:0];
  assign wr_s       = we & sel_s;
  assign clr_s      = wr_s & (reg_s == ADDR_CLEAR);
  assign tx_push_s  = wr_s & (reg_s == ADDR_TXDATA);
  assign tx_flush_s = clr_s & data_write[CLR_TX_FLUSH];
  assign rx_flush_s = clr_s & data_write[CLR_RX_FLUSH];
  assign rx_pop_s   = re & ~we & sel_s & (reg_s == ADDR_RXDATA) & ~rx_empty_s;
  assign tx_pop_s   = (tx_state_r == TX_IDLE) & ctrl_r[CTRL_TX_EN] & ~tx_empty_s & ~tx_flush_s;
  assign unused_bits_s = ^data_write[31:16];

  terminal_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push_s), .pop(tx_pop_s), .flush(tx_flush_s),
    .din(data_write[7:0]), .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s),
    .count(tx_count_s)
  );

  terminal_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push_s), .pop(rx_pop_s), .flush(rx_flush_s),
    .din(rx_shift_r), .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s),
    .count(rx_count_s)
  );

  // Writable configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      term_r <= 8'd0;
      ctrl_r <= CTRL_RESET;
      div_r  <= DEFAULT_DIV;
    end else if (wr_s) begin
      case (reg_s)
        ADDR_TERM:    term_r <= data_write[7:0];
        ADDR_CTRL:    ctrl_r <= data_write[3:0];
        ADDR_DIVISOR: div_r  <= clamp_div(data_write[15:0]);
        default:      term_r <= term_r;
      endcase
    end else begin
      term_r <= term_r;
    end
  end

  // Sticky flags (a same-cycle set beats the W1C clear) and the interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ovf_r    <= 1'b0;
      tx_ovf_r    <= 1'b0;
      frame_err_r <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      rx_ovf_r    <= (rx_push_s & rx_full_s & ~rx_pop_s) |
                     (rx_ovf_r & ~(clr_s & data_write[CLR_RX_OVF]));
      tx_ovf_r    <= (tx_push_s & tx_full_s & ~tx_pop_s) |
                     (tx_ovf_r & ~(clr_s & data_write[CLR_TX_OVF]));
      frame_err_r <= frame_err_set_s | (frame_err_r & ~(clr_s & data_write[CLR_FRAME_ERR]));
      irq_r       <= (ctrl_r[CTRL_IRQ_RX_EN] & ~rx_empty_s) | (ctrl_r[CTRL_IRQ_TX_EN] & tx_empty_s);
    end
  end

  assign tx_bit_end_s = (tx_cnt_r == tx_div_r - 16'd1);

  // Transmitter; txd_r follows the state one clock late, giving the pop-then-start latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_div_r   <= 16'd2;
      txd_r      <= 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          txd_r <= 1'b1;
          if (tx_pop_s) begin
            tx_state_r <= TX_START;
            tx_shift_r <= tx_dout_s;
            tx_div_r   <= div_r;
            tx_cnt_r   <= 16'd0;
          end
        end
        TX_START: begin
          txd_r <= 1'b0;
          if (tx_bit_end_s) begin
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_state_r <= TX_DATA;
          end else tx_cnt_r <= tx_cnt_r + 16'd1;
        end
        TX_DATA: begin
          txd_r <= tx_shift_r[0];
          if (tx_bit_end_s) begin
            tx_cnt_r   <= 16'd0;
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            if (tx_bit_r == 3'd7) tx_state_r <= TX_STOP;
            else                  tx_bit_r   <= tx_bit_r + 3'd1;
          end else tx_cnt_r <= tx_cnt_r + 16'd1;
        end
        TX_STOP: begin
          txd_r <= 1'b1;
          if (tx_bit_end_s) begin
            tx_cnt_r   <= 16'd0;
            tx_state_r <= TX_IDLE;
          end else tx_cnt_r <= tx_cnt_r + 16'd1;
        end
        default: tx_state_r <= TX_IDLE;
      endcase
    end
  end

  assign rxd_s           = sync_r[SYNC_STAGES-1];
  assign rx_half_s       = {1'b0, rx_div_r[15:1]} - 16'd1;
  assign rx_bit_end_s    = (rx_cnt_r == rx_div_r - 16'd1);
  assign rx_push_s       = (rx_state_r == RX_STOP) & rx_bit_end_s & rxd_s;
  assign frame_err_set_s = (rx_state_r == RX_STOP) & rx_bit_end_s & ~rxd_s;

  // Receiver: synchroniser, start-edge detect and mid-bit sampling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r     <= {SYNC_STAGES{1'b1}};
      rxd_prev_r <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
      rx_div_r   <= 16'd2;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], uart_rxd};
      rxd_prev_r <= rxd_s;
      case (rx_state_r)
        RX_IDLE: begin
          if (ctrl_r[CTRL_RX_EN] && rxd_prev_r && !rxd_s) begin
            rx_state_r <= RX_START;
            rx_div_r   <= div_r;
            rx_cnt_r   <= 16'd0;
          end
        end
        RX_START: begin
          if (rx_cnt_r == rx_half_s) begin
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_state_r <= rxd_s ? RX_IDLE : RX_DATA;
          end else rx_cnt_r <= rx_cnt_r + 16'd1;
        end
        RX_DATA: begin
          if (rx_bit_end_s) begin
            rx_cnt_r   <= 16'd0;
            rx_shift_r <= {rxd_s, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
            else                  rx_bit_r   <= rx_bit_r + 3'd1;
          end else rx_cnt_r <= rx_cnt_r + 16'd1;
        end
        RX_STOP: begin
          if (rx_bit_end_s) begin
            rx_cnt_r   <= 16'd0;
            rx_state_r <= RX_IDLE;
          end else rx_cnt_r <= rx_cnt_r + 16'd1;
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Combinational read mux.
  always_comb begin
    data_read = 32'd0;
    if (sel_s) begin
      case (reg_s)
        ADDR_TERM:    data_read = {24'd0, term_r};
        ADDR_RXDATA:  data_read = rx_empty_s ? 32'd0 : {24'd0, rx_dout_s};
        ADDR_STATUS:  data_read = {8'd0, 8'(tx_count_s), 8'(rx_count_s), frame_err_r, tx_ovf_r,
                                   rx_ovf_r, (tx_state_r != TX_IDLE), rx_full_s, rx_empty_s,
                                   tx_empty_s, tx_full_s};
        ADDR_CTRL:    data_read = {28'd0, ctrl_r};
        ADDR_DIVISOR: data_read = {16'd0, div_r};
        default:      data_read = 32'd0;
      endcase
    end else begin
      data_read = 32'd0;
    end
  end

  assign terminal_bus = term_r;
  assign uart_txd     = txd_r;
  assign irq          = irq_r;

endmodule

// File: tb/tb_terminal_uart.sv
// Self-checking bench for terminal_uart: randomized bytes and divisors checked
// against frame/queue reference models computed in the bench.
module tb_terminal_uart;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [31:0] addr = 32'd0, data_write = 32'd0;
  logic [31:0] data_read;
  logic [7:0]  terminal_bus;
  logic        uart_txd, uart_rxd, irq;
  logic        rxd_drv = 1'b1;
  logic        loop_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;
  always #5 clk = ~clk;

  terminal_uart #(.TX_DEPTH(16), .RX_DEPTH(16), .DEFAULT_DIV(16'd434), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .addr(addr), .data_write(data_write),
    .data_read(data_read), .terminal_bus(terminal_bus), .uart_txd(uart_txd),
    .uart_rxd(uart_rxd), .irq(irq)
  );

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; data_write = d; we = 1'b1; re = 1'b0;
    @(negedge clk); we = 1'b0; data_write = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic pop, output logic [31:0] d);
    @(negedge clk); addr = a; re = pop; #1 d = data_read;
    @(negedge clk); re = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr = a; #1 d = data_read;
  endtask

  task automatic wait_status(input int bit_lo, input int width, input int val, input int bound, output logic ok);
    logic [31:0] st;
    ok = 1'b0;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge clk); peek(32'd3, st);
      if (((st >> bit_lo) & ((32'd1 << width) - 32'd1)) == 32'(val)) ok = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = fr[i];
      repeat (div) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (2 * div) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; repeat (3) @(negedge clk); reset = 1'b0; @(negedge clk);
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", uart_txd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    checks++; if (terminal_bus !== 8'h00) begin errors++; $display("FAIL reset_term_bus got %h exp 00", terminal_bus); end
    bus_read(32'd3, 1'b0, d);
    checks++; if (d !== 32'h0000_0006) begin errors++; $display("FAIL reset_status got %h exp 00000006", d); end
    bus_read(32'd4, 1'b0, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL reset_ctrl got %h exp 3", d); end
    bus_read(32'd5, 1'b0, d);
    checks++; if (d !== 32'd434) begin errors++; $display("FAIL reset_divisor got %0d exp 434", d); end
    bus_read(32'd2, 1'b1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_rxdata got %h exp 0", d); end
    bus_read(32'd7, 1'b0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_addr7 got %h exp 0", d); end
  endtask

  task automatic test_term();
    logic [31:0] d, a;
    logic [7:0]  b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      bus_write(32'd0, {24'($urandom), b});
      checks++; if (terminal_bus !== b) begin errors++; $display("FAIL term_bus got %h exp %h", terminal_bus, b); end
      bus_read(32'd0, 1'b0, d);
      checks++; if (d !== {24'd0, b}) begin errors++; $display("FAIL term_read got %h exp %h", d, b); end
    end
    a = $urandom | 32'h8;
    bus_write(a, {24'd0, ~b});
    bus_write(32'd7, {24'd0, ~b});
    checks++; if (terminal_bus !== b) begin errors++; $display("FAIL undecoded_write got %h exp %h", terminal_bus, b); end
    bus_read({a[31:3], 3'd0}, 1'b0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL undecoded_read got %h exp 0", d); end
  endtask

  task automatic test_divisor();
    logic [31:0] d;
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = (i < 2) ? 16'(i) : 16'($urandom_range(2, 65535));
      bus_write(32'd5, {16'hFFFF, v});
      bus_read(32'd5, 1'b0, d);
      checks++;
      if (d !== {16'd0, (v < 16'd2) ? 16'd2 : v}) begin
        errors++; $display("FAIL divisor_write_%0d got %0d wrote %0d", i, d, v);
      end
    end
  endtask

  task automatic test_tx_frame();
    logic [31:0] st;
    logic [7:0]  b;
    logic        exp_b;
    int          div, bad, bitno;
    bus_write(32'd4, 32'h3);
    for (int f = 0; f < 3; f++) begin
      b   = (f == 0) ? 8'hA5 : 8'($urandom);
      div = (f == 0) ? 4 : $urandom_range(2, 5);
      bus_write(32'd5, 32'(div));
      bus_write(32'd1, {24'd0, b});
      bad = -1;
      for (int k = 0; k < 10 * div + 2; k++) begin
        @(negedge clk);
        if (k == 0 || k == 10 * div + 1) exp_b = 1'b1;
        else begin
          bitno = (k - 1) / div;
          exp_b = (bitno == 0) ? 1'b0 : (bitno == 9) ? 1'b1 : b[bitno-1];
        end
        if (uart_txd !== exp_b && bad < 0) bad = k;
        if (k == div) begin
          peek(32'd3, st);
          checks++; if (st[4] !== 1'b1) begin errors++; $display("FAIL tx_busy_mid got %b exp 1", st[4]); end
        end
      end
      checks++; if (bad >= 0) begin errors++; $display("FAIL tx_waveform byte %h div %0d got mismatch at clock %0d exp none", b, div, bad); end
      peek(32'd3, st);
      checks++; if (st[4:0] !== 5'b00110) begin errors++; $display("FAIL tx_done_status got %b exp 00110", st[4:0]); end
    end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    bus_write(32'd4, 32'h2);
    for (int i = 0; i < 17; i++) bus_write(32'd1, 32'($urandom));
    bus_read(32'd3, 1'b0, d);
    checks++; if (d !== 32'h0010_0045) begin errors++; $display("FAIL tx_ovf_status got %h exp 00100045", d); end
    bus_write(32'd6, 32'h40);
    bus_read(32'd3, 1'b0, d);
    checks++; if (d !== 32'h0010_0005) begin errors++; $display("FAIL tx_ovf_clear got %h exp 00100005", d); end
    bus_write(32'd6, 32'h100);
    bus_read(32'd3, 1'b0, d);
    checks++; if (d !== 32'h0000_0006) begin errors++; $display("FAIL tx_flush got %h exp 00000006", d); end
  endtask

  task automatic test_loopback();
    logic [31:0] d, st;
    logic [7:0]  q[$];
    logic [7:0]  b;
    logic        ok;
    int          div;
    div = $urandom_range(3, 6);
    bus_write(32'd4, 32'h2);
    bus_write(32'd5, 32'(div));
    for (int i = 0; i < 16; i++) begin
      b = (i == 0) ? 8'h3C : 8'($urandom);
      q.push_back(b);
      bus_write(32'd1, {24'd0, b});
    end
    loop_en = 1'b1;
    bus_write(32'd4, 32'h3);
    wait_status(8, 8, 16, 16 * (10 * div + 4) + 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_fill_timeout got no rx_count 16 exp 16"); end
    bus_write(32'd1, 32'($urandom));
    wait_status(5, 1, 1, 10 * div + 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rx_ovf_timeout got 0 exp 1"); end
    @(negedge clk); addr = 32'd2; data_write = 32'd0; we = 1'b1; re = 1'b1;
    @(negedge clk); we = 1'b0; re = 1'b0;
    peek(32'd3, st);
    checks++; if (st[15:8] !== 8'd16 || st[3] !== 1'b1) begin errors++; $display("FAIL rx_full_no_pop got count %0d full %b exp 16 1", st[15:8], st[3]); end
    for (int i = 0; i < 16; i++) begin
      bus_read(32'd2, 1'b1, d);
      checks++; if (d !== {24'd0, q[i]}) begin errors++; $display("FAIL rx_byte_%0d got %h exp %h", i, d, q[i]); end
    end
    bus_read(32'd2, 1'b0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rx_empty_read got %h exp 0", d); end
    bus_write(32'd6, 32'h20);
    bus_read(32'd3, 1'b0, d);
    checks++; if (d !== 32'h0000_0006) begin errors++; $display("FAIL rx_drained_status got %h exp 00000006", d); end
    loop_en = 1'b0;
  endtask

  task automatic test_frame_err();
    logic [31:0] d;
    logic [7:0]  b;
    bus_write(32'd5, 32'd8);
    send_frame(8'($urandom), 1'b0, 8);
    bus_read(32'd3, 1'b0, d);
    checks++; if (d !== 32'h0000_0086) begin errors++; $display("FAIL frame_err_status got %h exp 00000086", d); end
    bus_write(32'd6, 32'h80);
    bus_write(32'd5, 32'd10);
    @(negedge clk); rxd_drv = 1'b0; repeat (3) @(negedge clk); rxd_drv = 1'b1;
    repeat (25) @(negedge clk);
    bus_read(32'd3, 1'b0, d);
    checks++; if (d !== 32'h0000_0006) begin errors++; $display("FAIL glitch_status got %h exp 00000006", d); end
    b = 8'($urandom);
    send_frame(b, 1'b1, 10);
    bus_read(32'd2, 1'b1, d);
    checks++; if (d !== {24'd0, b}) begin errors++; $display("FAIL rx_driven_byte got %h exp %h", d, b); end
  endtask

  task automatic test_irq();
    logic [31:0] d, st;
    logic [7:0]  b;
    int          e_cyc, i_cyc;
    loop_en = 1'b1;
    bus_write(32'd5, 32'd4);
    bus_write(32'd4, 32'h7);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", irq); end
    b = 8'($urandom);
    bus_write(32'd1, {24'd0, b});
    e_cyc = -1; i_cyc = -1;
    for (int c = 0; c < 200 && i_cyc < 0; c++) begin
      peek(32'd3, st);
      if (e_cyc < 0 && st[2] == 1'b0) e_cyc = c;
      if (i_cyc < 0 && irq == 1'b1) i_cyc = c;
      @(negedge clk);
    end
    checks++; if (e_cyc < 0 || i_cyc != e_cyc + 1) begin errors++; $display("FAIL irq_rise got irq at %0d exp %0d", i_cyc, e_cyc + 1); end
    bus_read(32'd2, 1'b1, d);
    checks++; if (d !== {24'd0, b}) begin errors++; $display("FAIL irq_byte got %h exp %h", d, b); end
    peek(32'd3, st);
    checks++; if (irq !== 1'b1 || st[2] !== 1'b1) begin errors++; $display("FAIL irq_lag got irq %b empty %b exp 1 1", irq, st[2]); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got %b exp 0", irq); end
    bus_write(32'd4, 32'hB);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_tx_lag got %b exp 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty got %b exp 1", irq); end
    bus_write(32'd4, 32'h3);
    loop_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    bus_write(32'd5, 32'd8);
    bus_write(32'd1, 32'd0);
    repeat (10) @(negedge clk);
    checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL midframe_low got %b exp 0", uart_txd); end
    #2 reset = 1'b1;
    #1;
    checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL async_reset_txd got %b exp 1", uart_txd); end
    @(negedge clk); reset = 1'b0;
    bus_read(32'd3, 1'b0, d);
    checks++; if (d !== 32'h0000_0006) begin errors++; $display("FAIL post_reset_status got %h exp 00000006", d); end
    bus_read(32'd5, 1'b0, d);
    checks++; if (d !== 32'd434) begin errors++; $display("FAIL post_reset_divisor got %0d exp 434", d); end
  endtask

  initial begin
    test_reset();
    test_term();
    test_divisor();
    test_tx_frame();
    test_tx_overflow();
    test_loopback();
    test_frame_err();
    test_irq();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1);
  end

endmodule
